mips_decode_alu_unit: RTL and testbench

//  Decode/execute slice of the 5-stage MIPS pipeline: main control decode (opcode -> control

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/mips_alu.sv | 35 +++
 rtl/mips_alu_ctrl.sv | 35 +++
 rtl/mips_main_ctrl.sv | 59 +++++
 rtl/mips_decode_alu_unit.sv | 84 ++++++++
 tb/tb_mips_decode_alu_unit.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : opcode/funct codes, ALUOp and ALU-control encodings, control bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluctrl_e;

  typedef struct packed {
    logic   reg_dst;
    logic   branch;
    logic   branch_n;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    logic   jump;
    logic   alu_src;
    logic   reg_write;
    aluop_e alu_op;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips_alu.sv
//------------------------------------------------------------------------------
// mips_alu : combinational ALU; wrap-around add/sub, signed SLT, zero flag
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            ctrl_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  zero_o
);

  always_comb begin
    res_o = '0;
    case (ctrl_i)
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_ADD: res_o = a_i + b_i;
      ALU_SUB: res_o = a_i - b_i;
      ALU_SLT: res_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

`default_nettype wire

// File: rtl/mips_alu_ctrl.sv
//------------------------------------------------------------------------------
// mips_alu_ctrl : ALUOp + funct -> 3-bit ALU operation
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_alu_ctrl
  import mips_pkg::*;
(
  input  aluop_e     alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_SLT: alu_ctrl_o = ALU_SLT;
      default: begin
        case (funct_i)
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_main_ctrl.sv
//------------------------------------------------------------------------------
// mips_main_ctrl : opcode -> control bundle; kill_i squashes all controls to 0
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_main_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       kill_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (!kill_i) begin
      case (opcode_i)
        OP_RTYPE: begin
          ctrl_o.reg_dst   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALUOP_FUNCT;
        end
        OP_LW: begin
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.reg_write  = 1'b1;
        end
        OP_SW: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.mem_write = 1'b1;
        end
        OP_BEQ: begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = ALUOP_SUB;
        end
        OP_BNE: begin
          ctrl_o.branch_n = 1'b1;
          ctrl_o.alu_op   = ALUOP_SUB;
        end
        OP_ADDI: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
        end
        OP_SLTI: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALUOP_SLT;
        end
        OP_J:    ctrl_o.jump = 1'b1;
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_decode_alu_unit.sv
//------------------------------------------------------------------------------
// mips_decode_alu_unit : control decode + ALU with a registered EX/MEM result copy
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_decode_alu_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  no_op,
  input  logic [DATA_WIDTH-1:0] alu_a,
  input  logic [DATA_WIDTH-1:0] alu_b,
  output logic                  reg_dst,
  output logic                  branch,
  output logic                  branch_n,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  jump,
  output logic                  alu_src,
  output logic                  reg_write,
  output logic                  ld_pc,
  output logic [1:0]            alu_op,
  output logic [2:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_res,
  output logic                  alu_zero,
  output logic [DATA_WIDTH-1:0] res_q,
  output logic                  zero_q
);

  ctrl_t ctrl;

  // Reset and hazard bubbles both squash the decode in the same cycle.
  mips_main_ctrl u_main_ctrl (
    .opcode_i (opcode),
    .kill_i   (rst | no_op),
    .ctrl_o   (ctrl)
  );

  mips_alu_ctrl u_alu_ctrl (
    .alu_op_i   (ctrl.alu_op),
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl)
  );

  mips_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .ctrl_i (alu_ctrl),
    .res_o  (alu_res),
    .zero_o (alu_zero)
  );

  assign reg_dst    = ctrl.reg_dst;
  assign branch     = ctrl.branch;
  assign branch_n   = ctrl.branch_n;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign jump       = ctrl.jump;
  assign alu_src    = ctrl.alu_src;
  assign reg_write  = ctrl.reg_write;
  assign alu_op     = ctrl.alu_op;
  assign ld_pc      = ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      res_q  <= alu_res;
      zero_q <= alu_zero;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_decode_alu_unit.sv
// Testbench for mips_decode_alu_unit: directed cases plus randomized decode/ALU checks.
`default_nettype none

module tb_mips_decode_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        no_op;
  logic [31:0] alu_a, alu_b;
  logic        reg_dst, branch, branch_n, mem_read, mem_write, mem_to_reg;
  logic        jump, alu_src, reg_write, ld_pc, alu_zero, zero_q;
  logic [1:0]  alu_op;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_res, res_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_decode_alu_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .no_op(no_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .reg_dst(reg_dst), .branch(branch), .branch_n(branch_n), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .jump(jump), .alu_src(alu_src),
    .reg_write(reg_write), .ld_pc(ld_pc), .alu_op(alu_op), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_zero(alu_zero), .res_q(res_q), .zero_q(zero_q)
  );

  // Control vector order: reg_dst branch branch_n mem_read mem_write mem_to_reg jump alu_src reg_write alu_op[1:0]
  function automatic logic [10:0] model_ctrl(input logic [5:0] op, input logic kill);
    if (kill) return 11'd0;
    case (op)
      6'b000000: return {1'b1, 7'b0000000, 1'b1, 2'b10};
      6'b100011: return 11'b000101_1_1_1_00 & 11'b00010101100 | 11'b00010101100;
      6'b101011: return 11'b00001001000;
      6'b000100: return 11'b01000000001;
      6'b000101: return 11'b00100000001;
      6'b001000: return 11'b00000001100;
      6'b001010: return 11'b00000001111;
      6'b000010: return 11'b00000010000;
      default:   return 11'd0;
    endcase
  endfunction

  // Expected ALU result from the instruction's meaning rather than its encoding path.
  function automatic logic [31:0] model_alu(input logic [5:0] op, input logic [5:0] fn,
                                            input logic kill, input logic [31:0] a,
                                            input logic [31:0] b);
    string kind;
    kind = "add";
    if (!kill) begin
      if (op == 6'b000000) begin
        if (fn == 6'b100010) kind = "sub";
        else if (fn == 6'b100100) kind = "and";
        else if (fn == 6'b100101) kind = "or";
        else if (fn == 6'b101010) kind = "slt";
      end else if (op == 6'b000100 || op == 6'b000101) kind = "sub";
      else if (op == 6'b001010) kind = "slt";
    end
    if (kind == "sub") return a - b;
    if (kind == "and") return a & b;
    if (kind == "or")  return a | b;
    if (kind == "slt") return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    return a + b;
  endfunction

  function automatic logic [10:0] dut_ctrl();
    return {reg_dst, branch, branch_n, mem_read, mem_write, mem_to_reg, jump,
            alu_src, reg_write, alu_op};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic nop,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opcode = op; funct = fn; no_op = nop; alu_a = a; alu_b = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(6'b000000, 6'b100000, 1'b0, 32'd5, 32'd7);
    tests++;
    if (dut_ctrl() !== 11'd0) begin
      fails++; $display("FAIL reset_ctrl: got %b want %b", dut_ctrl(), 11'd0);
    end
    tests++;
    if (ld_pc !== 1'b0) begin
      fails++; $display("FAIL reset_ld_pc: got %b want 0", ld_pc);
    end
    @(posedge clk); #1;
    tests++;
    if (res_q !== 32'd0 || zero_q !== 1'b0) begin
      fails++; $display("FAIL reset_regs: got res_q=%h zero_q=%b want 0/0", res_q, zero_q);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ld_pc !== 1'b1) begin
      fails++; $display("FAIL ld_pc_run: got %b want 1", ld_pc);
    end
  endtask

  task automatic test_directed();
    drive(6'b000000, 6'b100000, 1'b0, 32'd5, 32'd7);
    tests++;
    if (reg_dst !== 1'b1 || reg_write !== 1'b1 || alu_ctrl !== 3'b010 || alu_res !== 32'd12) begin
      fails++; $display("FAIL r_add: got rd=%b rw=%b ctrl=%b res=%0d want 1 1 010 12",
                        reg_dst, reg_write, alu_ctrl, alu_res);
    end
    @(posedge clk); #1;
    tests++;
    if (res_q !== 32'd12) begin
      fails++; $display("FAIL r_add_q: got %0d want 12", res_q);
    end
    drive(6'b000000, 6'b101010, 1'b0, 32'hFFFFFFFF, 32'd1);
    tests++;
    if (alu_res !== 32'd1 || alu_zero !== 1'b0) begin
      fails++; $display("FAIL slt_neg: got res=%0d zero=%b want 1 0", alu_res, alu_zero);
    end
    drive(6'b000000, 6'b101010, 1'b0, 32'd1, 32'hFFFFFFFF);
    tests++;
    if (alu_res !== 32'd0 || alu_zero !== 1'b1) begin
      fails++; $display("FAIL slt_swap: got res=%0d zero=%b want 0 1", alu_res, alu_zero);
    end
    drive(6'b100011, 6'b000000, 1'b0, 32'd100, 32'd8);
    tests++;
    if (alu_src !== 1'b1 || mem_read !== 1'b1 || mem_to_reg !== 1'b1 || reg_write !== 1'b1 ||
        alu_res !== 32'd108) begin
      fails++; $display("FAIL lw: got src=%b mr=%b m2r=%b rw=%b res=%0d want 1 1 1 1 108",
                        alu_src, mem_read, mem_to_reg, reg_write, alu_res);
    end
    drive(6'b000100, 6'b000000, 1'b0, 32'd9, 32'd9);
    tests++;
    if (branch !== 1'b1 || alu_ctrl !== 3'b110 || alu_zero !== 1'b1) begin
      fails++; $display("FAIL beq: got br=%b ctrl=%b zero=%b want 1 110 1", branch, alu_ctrl, alu_zero);
    end
    drive(6'b000101, 6'b000000, 1'b0, 32'd9, 32'd9);
    tests++;
    if (branch_n !== 1'b1 || branch !== 1'b0) begin
      fails++; $display("FAIL bne: got bn=%b br=%b want 1 0", branch_n, branch);
    end
    drive(6'b100011, 6'b000000, 1'b1, 32'd100, 32'd8);
    tests++;
    if (dut_ctrl() !== 11'd0) begin
      fails++; $display("FAIL no_op_lw: got %b want 0", dut_ctrl());
    end
    drive(6'b111111, 6'b100010, 1'b0, 32'd3, 32'd4);
    tests++;
    if (dut_ctrl() !== 11'd0) begin
      fails++; $display("FAIL unknown_op: got %b want 0", dut_ctrl());
    end
    drive(6'b000000, 6'b000000, 1'b0, 32'd3, 32'd4);
    tests++;
    if (alu_ctrl !== 3'b010 || alu_res !== 32'd7) begin
      fails++; $display("FAIL funct_default: got ctrl=%b res=%0d want 010 7", alu_ctrl, alu_res);
    end
    drive(6'b000000, 6'b100000, 1'b0, 32'hFFFFFFFF, 32'd1);
    tests++;
    if (alu_res !== 32'd0 || alu_zero !== 1'b1) begin
      fails++; $display("FAIL add_wrap: got res=%h zero=%b want 0 1", alu_res, alu_zero);
    end
    @(posedge clk); #1;
    tests++;
    if (res_q !== 32'd0 || zero_q !== 1'b1) begin
      fails++; $display("FAIL add_wrap_q: got res_q=%h zero_q=%b want 0 1", res_q, zero_q);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [10];
    logic [5:0]  fns [7];
    logic [5:0]  op, fn;
    logic        nop;
    logic [31:0] a, b, exp_res;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b001000, 6'b001010, 6'b000010, 6'b111111, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};
    for (int i = 0; i < 300; i++) begin
      op  = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      fn  = ($urandom_range(0, 7) == 7) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      nop = ($urandom_range(0, 7) == 0);
      a   = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b   = ($urandom_range(0, 5) == 0) ? a : $urandom;
      drive(op, fn, nop, a, b);
      exp_res = model_alu(op, fn, nop, a, b);
      tests++;
      if (dut_ctrl() !== model_ctrl(op, nop)) begin
        fails++; $display("FAIL rand_ctrl op=%b nop=%b: got %b want %b", op, nop, dut_ctrl(), model_ctrl(op, nop));
      end
      tests++;
      if (alu_res !== exp_res || alu_zero !== (exp_res == 32'd0)) begin
        fails++; $display("FAIL rand_alu op=%b fn=%b a=%h b=%h: got %h/%b want %h/%b",
                          op, fn, a, b, alu_res, alu_zero, exp_res, exp_res == 32'd0);
      end
      @(posedge clk); #1;
      tests++;
      if (res_q !== exp_res || zero_q !== (exp_res == 32'd0)) begin
        fails++; $display("FAIL rand_reg: got %h/%b want %h/%b", res_q, zero_q, exp_res, exp_res == 32'd0);
      end
    end
  endtask

  task automatic test_reset_midrun();
    drive(6'b000000, 6'b100000, 1'b0, 32'd40, 32'd2);
    @(posedge clk); #1;
    tests++;
    if (res_q !== 32'd42) begin
      fails++; $display("FAIL midrun_pre: got %0d want 42", res_q);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (dut_ctrl() !== 11'd0 || ld_pc !== 1'b0) begin
      fails++; $display("FAIL midrun_ctrl: got %b ld_pc=%b want 0 0", dut_ctrl(), ld_pc);
    end
    @(posedge clk); #1;
    tests++;
    if (res_q !== 32'd0 || zero_q !== 1'b0) begin
      fails++; $display("FAIL midrun_clear: got %h/%b want 0/0", res_q, zero_q);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; no_op = 1'b0; alu_a = '0; alu_b = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
